rv32_mem_stage: RTL and testbench

Memory-access stage of the RV32I five-stage pipeline, directly downstream of the execute stage and upstream of write-back. Non-memory instructions pass through unchanged in one cycle. Loads and stores use a request/acknowledge data-memory bus. The stage does byte-lane steering for SB/SH/SW, sign/zero extension for LB/LH/LW/LBU/LHU, and misalignment detection. It stalls the pipeline while a bus transaction is outstanding.

---
 rtl/rv32_mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_rv32_mem_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_stage.sv
// RV32I memory-access stage.
// Non-memory instructions pass straight to write-back after one register stage.
// Loads and stores run a single request/acknowledge transaction on the
// data-memory bus. The stage steers store bytes onto the correct lanes,
// formats load data, and flags misaligned half/word accesses.
module rv32_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        mem_re_in,
  input  logic        mem_we_in,
  input  logic [31:0] mem_wr_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        wb_from_mem_out,
  output logic        misalign_err,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        access;
  logic        is_store;
  logic        misaligned;
  logic [2:0]  mem_f3;
  logic [1:0]  mem_off;
  logic        mem_re;

  assign funct3   = iw_in[14:12];
  assign off      = alu_in[1:0];
  assign access   = mem_re_in | mem_we_in;
  assign is_store = mem_we_in & ~mem_re_in;

  // Byte enables for a store; funct3 values beyond byte/half act as a word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << o;
      2'b01:   store_be = 4'b0011 << {o[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store source across every lane it might land in.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] format_load(input logic [31:0] rd, input logic [2:0] f3,
                                              input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{o, 3'b000} +: 8];
    h = rd[{o[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {24'd0, b};
      3'b101:  format_load = {16'd0, h};
      default: format_load = rd;
    endcase
  endfunction

  // Alignment check: halves need bit 0 clear, words (and undefined widths) both bits.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_in[0];
      default: misaligned = (alu_in[1:0] != 2'b00);
    endcase
  end

  // Freeze upstream while a transaction is being launched or is still waiting for ack.
  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE)
      mem_stall = access & ~misaligned;
    else
      mem_stall = ~dmem_ack;
  end

  // Forwarding taps straight from the execute-side inputs; loads cannot forward yet.
  assign df_mem_enable = wb_enable_in & ~mem_re_in;
  assign df_mem_reg    = wb_reg_in;
  assign df_mem_data   = alu_in;

  // Stage FSM: owns the bus registers and every write-back output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_be         <= 4'd0;
      dmem_wdata      <= 32'd0;
      mem_f3          <= 3'd0;
      mem_off         <= 2'd0;
      mem_re          <= 1'b0;
      pc_out          <= 32'd0;
      iw_out          <= 32'd0;
      wb_data_out     <= 32'd0;
      wb_reg_out      <= 5'd0;
      wb_enable_out   <= 1'b0;
      wb_from_mem_out <= 1'b0;
      misalign_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misalign_err <= 1'b0;
          dmem_req     <= 1'b0;
          if (!access) begin
            pc_out          <= pc_in;
            iw_out          <= iw_in;
            wb_reg_out      <= wb_reg_in;
            wb_enable_out   <= wb_enable_in;
            wb_data_out     <= alu_in;
            wb_from_mem_out <= 1'b0;
          end else if (misaligned) begin
            // Drop the access entirely and send a bubble with an error pulse.
            wb_enable_out   <= 1'b0;
            wb_from_mem_out <= 1'b0;
            misalign_err    <= 1'b1;
          end else begin
            dmem_req        <= 1'b1;
            dmem_we         <= is_store;
            dmem_addr       <= {alu_in[31:2], 2'b00};
            dmem_be         <= is_store ? store_be(funct3, off) : 4'b1111;
            dmem_wdata      <= store_data(funct3, mem_wr_data_in);
            mem_f3          <= funct3;
            mem_off         <= off;
            mem_re          <= mem_re_in;
            wb_enable_out   <= 1'b0;
            wb_from_mem_out <= 1'b0;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // Execute holds its outputs during the stall, so *_in still describe this access.
            dmem_req        <= 1'b0;
            pc_out          <= pc_in;
            iw_out          <= iw_in;
            wb_reg_out      <= wb_reg_in;
            wb_enable_out   <= wb_enable_in;
            wb_data_out     <= mem_re ? format_load(dmem_rdata, mem_f3, mem_off) : alu_in;
            wb_from_mem_out <= mem_re;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Self-checking bench for rv32_mem_stage: directed cases followed by random
// instruction traffic compared against an arithmetic reference model.
module tb_rv32_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, iw_in, alu_in, mem_wr_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_enable_in, mem_re_in, mem_we_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall;
  logic [31:0] pc_out, iw_out, wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_enable_out, wb_from_mem_out, misalign_err;
  logic        df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32_mem_stage dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
    .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in),
    .mem_re_in(mem_re_in), .mem_we_in(mem_we_in), .mem_wr_data_in(mem_wr_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out),
    .wb_from_mem_out(wb_from_mem_out), .misalign_err(misalign_err),
    .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (undefined widths behave as words).
  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % access_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = access_size(f3);
    int first = int'(a % 4);
    logic [3:0] be = 4'd0;
    for (int i = 0; i < sz; i++) be[first + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (access_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = access_size(f3);
    logic [31:0] raw = rd >> (8 * (a % 4));
    int v;
    if (sz == 4) return rd;
    if (sz == 1) begin
      v = int'(raw & 32'hFF);
      if (!f3[2] && v >= 128) v = v - 256;
    end else begin
      v = int'(raw & 32'hFFFF);
      if (!f3[2] && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    pc_in = 32'd0; iw_in = 32'd0; alu_in = 32'd0; wb_reg_in = 5'd0;
    wb_enable_in = 1'b0; mem_re_in = 1'b0; mem_we_in = 1'b0; mem_wr_data_in = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     32'(dmem_req), 32'd0);
    check({tag, "_we"},      32'(dmem_we), 32'd0);
    check({tag, "_addr"},    dmem_addr, 32'd0);
    check({tag, "_be"},      32'(dmem_be), 32'd0);
    check({tag, "_wdata"},   dmem_wdata, 32'd0);
    check({tag, "_pc"},      pc_out, 32'd0);
    check({tag, "_iw"},      iw_out, 32'd0);
    check({tag, "_wbdata"},  wb_data_out, 32'd0);
    check({tag, "_wbreg"},   32'(wb_reg_out), 32'd0);
    check({tag, "_wben"},    32'(wb_enable_out), 32'd0);
    check({tag, "_frommem"}, 32'(wb_from_mem_out), 32'd0);
    check({tag, "_misal"},   32'(misalign_err), 32'd0);
  endtask

  // Present one instruction at posedge+1 and follow it to write-back.
  // k = stall cycles the bus takes (ack arrives in the k-th cycle after detection).
  task automatic do_instr(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [4:0] wreg, input logic wen,
                          input logic re, input logic we, input logic [31:0] wd,
                          input int k, input logic [31:0] rd);
    logic [31:0] iw;
    bit acc, mis;
    int stalls;
    iw = $urandom;
    iw[14:12] = f3;
    acc = re | we;
    mis = acc && model_misaligned(f3, alu);
    pc_in = pc; iw_in = iw; alu_in = alu; wb_reg_in = wreg; wb_enable_in = wen;
    mem_re_in = re; mem_we_in = we; mem_wr_data_in = wd;
    #1;
    check({tag, "_df_en"},   32'(df_mem_enable), 32'(wen & ~re));
    check({tag, "_df_data"}, df_mem_data, alu);
    if (!acc || mis) begin
      check({tag, "_nostall"}, 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      check({tag, "_req"},   32'(dmem_req), 32'd0);
      check({tag, "_misal"}, 32'(misalign_err), 32'(mis));
      check({tag, "_wben"},  32'(wb_enable_out), mis ? 32'd0 : 32'(wen));
      if (!mis) begin
        check({tag, "_pc"},      pc_out, pc);
        check({tag, "_iw"},      iw_out, iw);
        check({tag, "_wbdata"},  wb_data_out, alu);
        check({tag, "_wbreg"},   32'(wb_reg_out), 32'(wreg));
        check({tag, "_frommem"}, 32'(wb_from_mem_out), 32'd0);
      end else begin
        idle_inputs();
        @(posedge clk); #1;
        check({tag, "_misal_end"}, 32'(misalign_err), 32'd0);
      end
    end else begin
      stalls = 0;
      for (int c = 0; c < k; c++) begin
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        if (c == 0) check({tag, "_bubble"}, 32'(wb_enable_out), 32'd0);
        check({tag, "_req"},  32'(dmem_req), 32'd1);
        check({tag, "_addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
        check({tag, "_we"},   32'(dmem_we), 32'(we & ~re));
        check({tag, "_be"},   32'(dmem_be), re ? 32'hF : 32'(model_be(f3, alu)));
        if (we && !re) check({tag, "_wdata"}, dmem_wdata, model_wdata(f3, wd));
        if (c == k - 1) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
          #1;
          check({tag, "_ackstall"}, 32'(mem_stall), 32'd0);
        end else begin
          dmem_rdata = $urandom;
        end
      end
      check({tag, "_stallcnt"}, 32'(stalls), 32'(k));
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
      check({tag, "_pc"},       pc_out, pc);
      check({tag, "_iw"},       iw_out, iw);
      check({tag, "_wbreg"},    32'(wb_reg_out), 32'(wreg));
      check({tag, "_wben"},     32'(wb_enable_out), 32'(wen));
      check({tag, "_frommem"},  32'(wb_from_mem_out), 32'(re));
      if (re) check({tag, "_wbdata"}, wb_data_out, model_load(f3, alu, rd));
    end
  endtask

  initial begin
    logic [2:0] load_f3 [7];
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    do_instr("add", 32'h100, 3'd0, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 0, 32'd0);
    do_instr("lb",  32'h104, 3'd0, 32'h1003, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0, 3, 32'h80FF_FF7F);
    do_instr("lhu", 32'h108, 3'd5, 32'h2002, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, 1, 32'hBEEF_0000);
    do_instr("lw",  32'h10C, 3'd2, 32'h2000, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0, 2, 32'hBEEF_0000);
    do_instr("sb",  32'h110, 3'd0, 32'h3001, 5'd0, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 2, 32'd0);
    do_instr("sh",  32'h114, 3'd1, 32'h3002, 5'd0, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 1, 32'd0);
    do_instr("mis_lw", 32'h118, 3'd2, 32'h4001, 5'd9, 1'b1, 1'b1, 1'b0, 32'd0, 1, 32'd0);
    do_instr("mis_sh", 32'h11C, 3'd1, 32'h4003, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1, 32'd0);

    // A stray ack while idle must not disturb a plain instruction
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    do_instr("idle_ack", 32'h120, 3'd2, 32'h5555, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 0, 32'd0);
    dmem_ack = 1'b0;

    // Reset in the middle of an outstanding load
    pc_in = 32'h124; iw_in = 32'h0000_2003; alu_in = 32'h5000; wb_reg_in = 5'd4;
    wb_enable_in = 1'b1; mem_re_in = 1'b1; mem_we_in = 1'b0; mem_wr_data_in = 32'd0;
    @(posedge clk); #1;
    check("rst_pre_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_stall", 32'(mem_stall), 32'd0);
    check_all_zero("rst_mid");
    do_instr("post_rst_lh", 32'h128, 3'd1, 32'h6002, 5'd10, 1'b1, 1'b1, 1'b0, 32'd0, 2,
             32'h8001_7FFE);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      logic [2:0]  f;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      case (kind)
        0: do_instr("rnd_alu", $urandom, 3'($urandom), a, 5'($urandom), 1'($urandom),
                    1'b0, 1'b0, 32'd0, 0, 32'd0);
        1: begin
          f = load_f3[$urandom_range(0, 6)];
          do_instr("rnd_ld", $urandom, f, a, 5'($urandom), 1'b1, 1'b1, 1'b0, 32'd0,
                   $urandom_range(1, 4), $urandom);
        end
        default: begin
          f = 3'($urandom_range(0, 2));
          do_instr("rnd_st", $urandom, f, a, 5'($urandom), 1'b0, 1'b0, 1'b1, $urandom,
                   $urandom_range(1, 4), 32'd0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
